// File: rtl/pin_memory_pkg.sv
// Shared definitions for the pin_memory block: compare FSM state type and
// default geometry constants.
package pin_memory_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/pin_memory_cmp.sv
// Compare engine for pin_memory: snapshots a candidate vector on cmp_start,
// walks the stored entries one per cycle and reports whether all matched.
// The storage itself lives in the parent; this block only drives scan_idx
// and looks at the entry value the parent returns for it.
module pin_memory_cmp
    import pin_memory_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DEPTH*WIDTH-1:0] data,
    input  logic [WIDTH-1:0]       entry,
    output logic [IDX_W-1:0]       scan_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   match,
    output cmp_state_t             state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    cmp_state_t       state_q;
    cmp_state_t       state_d;
    logic [IDX_W-1:0] counter;
    logic             mismatch;
    logic             match_q;
    logic [WIDTH-1:0] cap [DEPTH];
    logic             diff;

    assign diff     = (entry != cap[counter]);
    assign scan_idx = counter;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign match    = match_q;
    assign state    = state_q;

    // Next-state logic: start is only honoured from IDLE, so a start while
    // busy is naturally ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (counter == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, snapshot capture, scan counter and sticky mismatch.
    // The result is registered on the last SCAN edge so it is already
    // visible while DONE is asserted, and it holds until the next DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            counter  <= '0;
            mismatch <= 1'b0;
            match_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) cap[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        counter  <= '0;
                        mismatch <= 1'b0;
                        for (int i = 0; i < DEPTH; i++) cap[i] <= data[i*WIDTH +: WIDTH];
                    end
                end
                SCAN: begin
                    if (diff) mismatch <= 1'b1;
                    if (counter == LAST_IDX) match_q <= ~(mismatch | diff);
                    else                     counter <= counter + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pin_memory.sv
// pin_memory: small register-file memory with registered reads and a
// sequential compare against a candidate vector.
// Optional feature macro: PIN_MEMORY_WRLOCK_EN enables the wr_lock write
// protect input; without it wr_lock has no effect.
// Writes are dropped (with a one-cycle wr_err pulse) while a compare is
// running, so the stored entries cannot change under the scan.
module pin_memory
    import pin_memory_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   wr,
    input  logic [IDX_W-1:0]       idx,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rvalid,
    input  logic                   cmp_start,
    input  logic [DEPTH*WIDTH-1:0] cmp_data,
    output logic                   cmp_busy,
    output logic                   cmp_done,
    output logic                   cmp_match,
    input  logic                   wr_lock,
    output logic                   wr_err
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] scan_idx;
    logic             busy;
    logic             lock_hit;
    logic             wr_req;
    logic             wr_ok;
    cmp_state_t       cmp_state;

`ifdef PIN_MEMORY_WRLOCK_EN
    assign lock_hit = wr_lock;
`else
    logic unused_wr_lock;
    assign unused_wr_lock = wr_lock;
    assign lock_hit       = 1'b0;
`endif

    assign wr_req   = enable & wr;
    assign wr_ok    = wr_req & ~busy & ~lock_hit;
    assign cmp_busy = busy;

    pin_memory_cmp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_cmp (
        .clk      (clk),
        .reset    (reset),
        .start    (cmp_start),
        .data     (cmp_data),
        .entry    (mem[scan_idx]),
        .scan_idx (scan_idx),
        .busy     (busy),
        .done     (cmp_done),
        .match    (cmp_match),
        .state    (cmp_state)
    );

    // Storage array: cleared on reset, written only by accepted writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[idx] <= wdata;
        end
    end

    // Registered read port and rejected-write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            rvalid <= enable & ~wr;
            rdata  <= (enable & ~wr) ? mem[idx] : '0;
            wr_err <= wr_req & (busy | lock_hit);
        end
    end

endmodule

// File: tb/tb_pin_memory.sv
// Directed testbench for pin_memory (default WIDTH=4, DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_pin_memory;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int IDX_W = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   enable;
    logic                   wr;
    logic [IDX_W-1:0]       idx;
    logic [WIDTH-1:0]       wdata;
    logic [WIDTH-1:0]       rdata;
    logic                   rvalid;
    logic                   cmp_start;
    logic [DEPTH*WIDTH-1:0] cmp_data;
    logic                   cmp_busy;
    logic                   cmp_done;
    logic                   cmp_match;
    logic                   wr_lock;
    logic                   wr_err;

    int checks = 0;
    int errors = 0;

    // clock
    always #5 clk = ~clk;

    pin_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .wr        (wr),
        .idx       (idx),
        .wdata     (wdata),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .cmp_start (cmp_start),
        .cmp_data  (cmp_data),
        .cmp_busy  (cmp_busy),
        .cmp_done  (cmp_done),
        .cmp_match (cmp_match),
        .wr_lock   (wr_lock),
        .wr_err    (wr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        enable    = 1'b0;
        wr        = 1'b0;
        idx       = '0;
        wdata     = '0;
        cmp_start = 1'b0;
        wr_lock   = 1'b0;
    endtask

    task automatic do_write(input logic [IDX_W-1:0] i, input logic [WIDTH-1:0] d);
        enable = 1'b1; wr = 1'b1; idx = i; wdata = d;
        tick();
        idle_inputs();
    endtask

    task automatic do_read(input logic [IDX_W-1:0] i, input logic [WIDTH-1:0] exp, input string tag);
        enable = 1'b1; wr = 1'b0; idx = i;
        tick();
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check({tag, "_rdata"}, 32'(rdata), 32'(exp));
        idle_inputs();
    endtask

    initial begin
        logic [WIDTH-1:0] seed_vals [DEPTH];
        seed_vals[0] = 4'h1; seed_vals[1] = 4'h2; seed_vals[2] = 4'h3; seed_vals[3] = 4'h4;

        // reset
        idle_inputs();
        cmp_data = '0;
        reset = 1'b1;
        tick(); tick();
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_busy", 32'(cmp_busy), 32'd0);
        check("rst_done", 32'(cmp_done), 32'd0);
        check("rst_match", 32'(cmp_match), 32'd0);
        check("rst_wr_err", 32'(wr_err), 32'd0);
        reset = 1'b0;

        // all entries read back zero after reset
        for (int i = 0; i < DEPTH; i++) do_read(IDX_W'(i), 4'h0, "rst_read");

        // fill 1,2,3,4; a write cycle is not a read
        for (int i = 0; i < DEPTH; i++) begin
            enable = 1'b1; wr = 1'b1; idx = IDX_W'(i); wdata = seed_vals[i];
            tick();
            check("wr_rvalid", 32'(rvalid), 32'd0);
            check("wr_err_free", 32'(wr_err), 32'd0);
        end
        idle_inputs();
        do_read(2'd2, 4'h3, "read_idx2");
        do_read(2'd0, 4'h1, "read_idx0");
        do_read(2'd3, 4'h4, "read_idx3");

        // idle cycle: no strobe, data forced to zero
        tick();
        check("idle_rvalid", 32'(rvalid), 32'd0);
        check("idle_rdata", 32'(rdata), 32'd0);

        // compare that matches; candidate changed mid-scan must not matter
        cmp_data = 16'h4321; cmp_start = 1'b1;
        tick();                                  // cycle 1
        cmp_start = 1'b0;
        check("m_busy_c1", 32'(cmp_busy), 32'd1);
        check("m_done_c1", 32'(cmp_done), 32'd0);
        cmp_data = 16'h0000;
        tick();                                  // cycle 2
        check("m_done_c2", 32'(cmp_done), 32'd0);
        tick();                                  // cycle 3
        tick();                                  // cycle 4
        check("m_done_c4", 32'(cmp_done), 32'd0);
        tick();                                  // cycle 5
        check("m_done_c5", 32'(cmp_done), 32'd1);
        check("m_busy_c5", 32'(cmp_busy), 32'd1);
        check("m_match_c5", 32'(cmp_match), 32'd1);
        tick();                                  // cycle 6
        check("m_done_c6", 32'(cmp_done), 32'd0);
        check("m_busy_c6", 32'(cmp_busy), 32'd0);
        check("m_match_hold", 32'(cmp_match), 32'd1);

        // mismatching compare with a write and a second start during the scan
        cmp_data = 16'h4301; cmp_start = 1'b1;
        tick();                                  // cycle 1
        cmp_start = 1'b1;                        // ignored: busy
        enable = 1'b1; wr = 1'b1; idx = 2'd0; wdata = 4'hF;
        tick();                                  // cycle 2
        idle_inputs();
        check("busy_wr_err", 32'(wr_err), 32'd1);
        check("x_match_hold", 32'(cmp_match), 32'd1);
        check("x_done_c2", 32'(cmp_done), 32'd0);
        tick();                                  // cycle 3
        check("busy_wr_err_pulse", 32'(wr_err), 32'd0);
        tick();                                  // cycle 4
        check("x_done_c4", 32'(cmp_done), 32'd0);
        tick();                                  // cycle 5
        check("x_done_c5", 32'(cmp_done), 32'd1);
        check("x_match_c5", 32'(cmp_match), 32'd0);
        tick();                                  // cycle 6
        check("x_done_c6", 32'(cmp_done), 32'd0);
        check("x_busy_c6", 32'(cmp_busy), 32'd0);
        check("x_match_hold", 32'(cmp_match), 32'd0);
        do_read(2'd0, 4'h1, "busy_wr_dropped");

        // reads are serviced during a scan
        cmp_data = 16'h4321; cmp_start = 1'b1;
        tick();
        cmp_start = 1'b0;
        do_read(2'd1, 4'h2, "scan_read");
        // reset at SCAN cycle 2 aborts the compare
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(cmp_busy), 32'd0);
        check("abort_done", 32'(cmp_done), 32'd0);
        check("abort_match", 32'(cmp_match), 32'd0);
        begin
            int seen_done = 0;
            for (int k = 0; k < DEPTH + 2; k++) begin
                tick();
                if (cmp_done) seen_done++;
            end
            check("abort_no_done", 32'(seen_done), 32'd0);
        end
        for (int i = 0; i < DEPTH; i++) do_read(IDX_W'(i), 4'h0, "abort_cleared");

        // write protect
        for (int i = 0; i < DEPTH; i++) do_write(IDX_W'(i), seed_vals[i]);
        enable = 1'b1; wr = 1'b1; idx = 2'd1; wdata = 4'hF; wr_lock = 1'b1;
        tick();
        idle_inputs();
`ifdef PIN_MEMORY_WRLOCK_EN
        check("lock_wr_err", 32'(wr_err), 32'd1);
        do_read(2'd1, 4'h2, "lock_dropped");
`else
        check("lock_ignored_err", 32'(wr_err), 32'd0);
        do_read(2'd1, 4'hF, "lock_ignored");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
